// File: rtl/writeback_arbiter_if.sv
// writeback_arbiter_if: ALU/load/regfile/hazard bundle; master = pipeline side, slave = arbiter
interface writeback_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_rd;
  logic        ld_issue_ready;
  logic        ld_resp_valid;
  logic [31:0] ld_resp_data;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        reg_write;
  logic [4:0]  q_rs1_addr;
  logic [4:0]  q_rs2_addr;
  logic        q_rs1_busy;
  logic        q_rs2_busy;
  logic        protocol_err;
  modport master (
    output alu_valid, alu_rd, alu_data, ld_issue_valid, ld_issue_rd,
           ld_resp_valid, ld_resp_data, q_rs1_addr, q_rs2_addr,
    input  alu_ready, ld_issue_ready, rd_addr, rd_data, reg_write,
           q_rs1_busy, q_rs2_busy, protocol_err
  );
  modport slave (
    input  alu_valid, alu_rd, alu_data, ld_issue_valid, ld_issue_rd,
           ld_resp_valid, ld_resp_data, q_rs1_addr, q_rs2_addr,
    output alu_ready, ld_issue_ready, rd_addr, rd_data, reg_write,
           q_rs1_busy, q_rs2_busy, protocol_err
  );
endinterface

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU results and in-order load responses onto one registered regfile write port
// clk, rst_n (sync, active-low); wb: slave side of writeback_arbiter_if (ALU offer, load issue/response,
// regfile write, combinational hazard query, sticky protocol_err)
module writeback_arbiter #(
  parameter int LD_DEPTH = 4
) (
  input logic                clk,
  input logic                rst_n,
  writeback_arbiter_if.slave wb
);
  localparam int PW = $clog2(LD_DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(LD_DEPTH);
  logic [4:0]    tag_q [LD_DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic [31:1]   busy_q, busy_d;
  logic [31:0]   busy_vec, busy_n;
  logic          we_q, we_d, err_q, err_d;
  logic [4:0]    addr_q, addr_d, head;
  logic [31:0]   data_q, data_d;
  logic          full, empty, push, pop, alu_acc;
  always_comb begin
    // bit 0 is a hard zero so x0 never reads as busy
    busy_vec = {busy_q, 1'b0};
    full = cnt_q == FULL;
    empty = cnt_q == '0;
    head = tag_q[rd_q];
    // both readiness terms use registered state only; a same-cycle retire does not unblock
    wb.ld_issue_ready = !full && !busy_vec[wb.ld_issue_rd];
    wb.alu_ready = !wb.ld_resp_valid;
    wb.q_rs1_busy = busy_vec[wb.q_rs1_addr];
    wb.q_rs2_busy = busy_vec[wb.q_rs2_addr];
    push = rst_n && wb.ld_issue_valid && wb.ld_issue_ready;
    pop = rst_n && wb.ld_resp_valid && !empty;
    alu_acc = rst_n && wb.alu_valid && wb.alu_ready;
    err_d = err_q || (rst_n && wb.ld_resp_valid && empty) || (alu_acc && busy_vec[wb.alu_rd]);
    // an issue can never target the tag being retired (it is busy), so set/clear never collide
    busy_n = (busy_vec & ~(pop ? 32'd1 << head : 32'd0)) | (push ? 32'd1 << wb.ld_issue_rd : 32'd0);
    busy_d = busy_n[31:1];
    cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    we_d = pop ? head != '0 : alu_acc && wb.alu_rd != '0;
    addr_d = pop ? head : alu_acc ? wb.alu_rd : addr_q;
    data_d = pop ? wb.ld_resp_data : alu_acc ? wb.alu_data : data_q;
    wb.reg_write = we_q;
    wb.rd_addr = addr_q;
    wb.rd_data = data_q;
    wb.protocol_err = err_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      busy_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (push) tag_q[wr_q] <= wb.ld_issue_rd;
      wr_q <= wr_q + PW'(push);
      rd_q <= rd_q + PW'(pop);
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      err_q <= err_d;
    end
  end
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed table, corner sequences and random traffic against a queue-based model
module tb_writeback_arbiter;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  writeback_arbiter_if wb();
  writeback_arbiter #(.LD_DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .wb(wb));
  always #5 clk = ~clk;
  int checks = 0;
  int failures = 0;
  logic [4:0]  mq[$];
  logic        m_we, m_err;
  logic [4:0]  m_a;
  logic [31:0] m_d;
  logic        s_ardy, s_irdy, s_b1, s_b2;
  typedef struct {
    logic av; logic [4:0] ar; logic [31:0] ad;
    logic iv; logic [4:0] ir;
    logic rv; logic [31:0] rd;
    logic [4:0] q;
    logic ebusy, eardy, eirdy, ewe; logic [4:0] ea; logic [31:0] ed; logic eerr;
  } vec_t;
  vec_t tv[14];
  function automatic logic mbusy(input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    foreach (mq[i]) if (mq[i] == a) return 1'b1;
    return 1'b0;
  endfunction
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
    end
  endtask
  task automatic cyc(input logic r, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic iv, input logic [4:0] ir, input logic rv, input logic [31:0] rdd,
                     input logic [4:0] q1, input logic [4:0] q2);
    logic e_irdy, acc, iss;
    logic [4:0] h;
    rst_n = r;
    wb.alu_valid = av; wb.alu_rd = ar; wb.alu_data = ad;
    wb.ld_issue_valid = iv; wb.ld_issue_rd = ir;
    wb.ld_resp_valid = rv; wb.ld_resp_data = rdd;
    wb.q_rs1_addr = q1; wb.q_rs2_addr = q2;
    #1;
    s_ardy = wb.alu_ready; s_irdy = wb.ld_issue_ready; s_b1 = wb.q_rs1_busy; s_b2 = wb.q_rs2_busy;
    e_irdy = mq.size() < D && !mbusy(ir);
    chk("alu_ready", {31'd0, s_ardy}, {31'd0, !rv});
    chk("ld_issue_ready", {31'd0, s_irdy}, {31'd0, e_irdy});
    chk("q_rs1_busy", {31'd0, s_b1}, {31'd0, mbusy(q1)});
    chk("q_rs2_busy", {31'd0, s_b2}, {31'd0, mbusy(q2)});
    if (!r) begin
      mq.delete(); m_we = 1'b0; m_a = 5'd0; m_d = 32'd0; m_err = 1'b0;
    end else begin
      acc = av && !rv;
      iss = iv && e_irdy;
      if (acc && mbusy(ar)) m_err = 1'b1;
      if (rv && mq.size() == 0) m_err = 1'b1;
      if (rv && mq.size() > 0) begin
        h = mq.pop_front(); m_we = h != 5'd0; m_a = h; m_d = rdd;
      end else if (acc) begin
        m_we = ar != 5'd0; m_a = ar; m_d = ad;
      end else m_we = 1'b0;
      if (iss) mq.push_back(ir);
    end
    @(posedge clk);
    #1;
    chk("reg_write", {31'd0, wb.reg_write}, {31'd0, m_we});
    chk("rd_addr", {27'd0, wb.rd_addr}, {27'd0, m_a});
    chk("rd_data", wb.rd_data, m_d);
    chk("protocol_err", {31'd0, wb.protocol_err}, {31'd0, m_err});
  endtask
  task automatic idle(input logic r, input logic [4:0] q1, input logic [4:0] q2);
    cyc(r, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 32'd0, q1, q2);
  endtask
  task automatic issue(input logic [4:0] ir, input logic rv, input logic [31:0] rdd, input logic [4:0] q1);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, ir, rv, rdd, q1, 5'd0);
  endtask
  initial begin
    tv = '{
      '{1'b1,5'd5,32'hDEADBEEF,1'b0,5'd0,1'b0,32'h0,  5'd7,1'b0,1'b1,1'b1, 1'b1,5'd5,32'hDEADBEEF,1'b0},
      '{1'b0,5'd0,32'h0,       1'b0,5'd0,1'b0,32'h0,  5'd7,1'b0,1'b1,1'b1, 1'b0,5'd5,32'hDEADBEEF,1'b0},
      '{1'b0,5'd0,32'h0,       1'b1,5'd3,1'b0,32'h0,  5'd3,1'b0,1'b1,1'b1, 1'b0,5'd5,32'hDEADBEEF,1'b0},
      '{1'b0,5'd0,32'h0,       1'b1,5'd7,1'b0,32'h0,  5'd3,1'b1,1'b1,1'b1, 1'b0,5'd5,32'hDEADBEEF,1'b0},
      '{1'b0,5'd0,32'h0,       1'b0,5'd0,1'b1,32'h11, 5'd7,1'b1,1'b0,1'b1, 1'b1,5'd3,32'h11,1'b0},
      '{1'b0,5'd0,32'h0,       1'b0,5'd0,1'b1,32'h22, 5'd7,1'b1,1'b0,1'b1, 1'b1,5'd7,32'h22,1'b0},
      '{1'b0,5'd0,32'h0,       1'b0,5'd0,1'b0,32'h0,  5'd7,1'b0,1'b1,1'b1, 1'b0,5'd7,32'h22,1'b0},
      '{1'b0,5'd0,32'h0,       1'b1,5'd9,1'b0,32'h0,  5'd9,1'b0,1'b1,1'b1, 1'b0,5'd7,32'h22,1'b0},
      '{1'b1,5'd4,32'hAA,      1'b0,5'd0,1'b1,32'h99, 5'd9,1'b1,1'b0,1'b1, 1'b1,5'd9,32'h99,1'b0},
      '{1'b1,5'd4,32'hAA,      1'b0,5'd0,1'b0,32'h0,  5'd9,1'b0,1'b1,1'b1, 1'b1,5'd4,32'hAA,1'b0},
      '{1'b0,5'd0,32'h0,       1'b1,5'd0,1'b0,32'h0,  5'd0,1'b0,1'b1,1'b1, 1'b0,5'd4,32'hAA,1'b0},
      '{1'b0,5'd0,32'h0,       1'b0,5'd0,1'b1,32'h55, 5'd0,1'b0,1'b0,1'b1, 1'b0,5'd0,32'h55,1'b0},
      '{1'b0,5'd0,32'h0,       1'b0,5'd0,1'b1,32'h66, 5'd0,1'b0,1'b0,1'b1, 1'b0,5'd0,32'h55,1'b1},
      '{1'b0,5'd0,32'h0,       1'b0,5'd0,1'b0,32'h0,  5'd0,1'b0,1'b1,1'b1, 1'b0,5'd0,32'h55,1'b1}
    };
    wb.alu_valid = 1'b0; wb.alu_rd = 5'd0; wb.alu_data = 32'd0;
    wb.ld_issue_valid = 1'b0; wb.ld_issue_rd = 5'd0;
    wb.ld_resp_valid = 1'b0; wb.ld_resp_data = 32'd0;
    wb.q_rs1_addr = 5'd0; wb.q_rs2_addr = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete(); m_we = 1'b0; m_a = 5'd0; m_d = 32'd0; m_err = 1'b0;
    idle(1'b0, 5'd0, 5'd0);
    for (int i = 0; i < 14; i++) begin
      cyc(1'b1, tv[i].av, tv[i].ar, tv[i].ad, tv[i].iv, tv[i].ir, tv[i].rv, tv[i].rd, tv[i].q, tv[i].q);
      chk($sformatf("vec%0d_busy", i), {31'd0, s_b1}, {31'd0, tv[i].ebusy});
      chk($sformatf("vec%0d_alu_ready", i), {31'd0, s_ardy}, {31'd0, tv[i].eardy});
      chk($sformatf("vec%0d_issue_ready", i), {31'd0, s_irdy}, {31'd0, tv[i].eirdy});
      chk($sformatf("vec%0d_we", i), {31'd0, wb.reg_write}, {31'd0, tv[i].ewe});
      chk($sformatf("vec%0d_addr", i), {27'd0, wb.rd_addr}, {27'd0, tv[i].ea});
      chk($sformatf("vec%0d_data", i), wb.rd_data, tv[i].ed);
      chk($sformatf("vec%0d_err", i), {31'd0, wb.protocol_err}, {31'd0, tv[i].eerr});
    end
    idle(1'b0, 5'd0, 5'd0);
    chk("reset_err_clear", {31'd0, wb.protocol_err}, 32'd0);
    for (int i = 1; i <= 4; i++) issue(5'(i), 1'b0, 32'd0, 5'd0);
    issue(5'd5, 1'b1, 32'h100, 5'd0);
    chk("full_blocks_issue", {31'd0, s_irdy}, 32'd0);
    chk("full_pop_write_x1", {27'd0, wb.rd_addr}, 32'd1);
    issue(5'd5, 1'b0, 32'd0, 5'd0);
    chk("ready_after_pop", {31'd0, s_irdy}, 32'd1);
    issue(5'd2, 1'b1, 32'h200, 5'd2);
    chk("same_rd_blocks", {31'd0, s_irdy}, 32'd0);
    chk("same_rd_busy_before", {31'd0, s_b1}, 32'd1);
    issue(5'd2, 1'b0, 32'd0, 5'd2);
    chk("same_rd_next_ready", {31'd0, s_irdy}, 32'd1);
    chk("same_rd_cleared", {31'd0, s_b1}, 32'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h300, 5'd0, 5'd0);
    issue(5'd6, 1'b1, 32'h400, 5'd6);
    chk("push_pop_ready", {31'd0, s_irdy}, 32'd1);
    issue(5'd7, 1'b0, 32'd0, 5'd6);
    chk("push_pop_count_kept", {31'd0, s_irdy}, 32'd1);
    chk("push_pop_busy6", {31'd0, s_b1}, 32'd1);
    issue(5'd8, 1'b0, 32'd0, 5'd0);
    chk("count_full_again", {31'd0, s_irdy}, 32'd0);
    cyc(1'b1, 1'b1, 5'd5, 32'h77, 1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 5'd0);
    chk("waw_err", {31'd0, wb.protocol_err}, 32'd1);
    chk("waw_written", {31'd0, wb.reg_write}, 32'd1);
    idle(1'b0, 5'd0, 5'd0);
    issue(5'd8, 1'b0, 32'd0, 5'd0);
    issue(5'd9, 1'b0, 32'd0, 5'd0);
    cyc(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 1'b0, 32'd0, 5'd8, 5'd9);
    chk("reset_ready_follows_eq", {31'd0, s_irdy}, 32'd1);
    chk("reset_busy_before", {31'd0, s_b1}, 32'd1);
    idle(1'b1, 5'd8, 5'd10);
    chk("reset_cleared_busy8", {31'd0, s_b1}, 32'd0);
    chk("reset_no_accept_x10", {31'd0, s_b2}, 32'd0);
    cyc(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 32'h500, 5'd9, 5'd0);
    chk("reset_resp_err", {31'd0, wb.protocol_err}, 32'd1);
    chk("reset_resp_no_write", {31'd0, wb.reg_write}, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
          1'($urandom_range(0, 1)), 5'($urandom_range(0, 9)), 1'($urandom_range(0, 9) < 4), $urandom,
          5'($urandom_range(0, 9)), 5'($urandom_range(0, 9)));
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
